// File: rtl/openframe_gpio_event.sv
// GPIO pad edge monitor: synchronises the pads, detects qualified rising/falling edges and
// queues {pad, polarity} events in a first-word-fall-through FIFO, counting any lost edges.
module openframe_gpio_event #(
    parameter int NPADS = 44,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             rstb_l,
    input  logic [NPADS-1:0] gpio_in,
    input  logic [NPADS-1:0] enable_mask,
    input  logic             rise_en,
    input  logic             fall_en,
    output logic [NPADS-1:0] gpio_sync,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [5:0]       evt_pad,
    output logic             evt_rising,
    output logic [7:0]       drop_count,
    input  logic             clear_drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NPADS-1:0] s1, s2, s3;
    logic [1:0]       arm_cnt;
    logic             armed;
    logic [NPADS-1:0] pend_r, pend_f;
    logic [NPADS-1:0] edge_r, edge_f;
    logic [NPADS-1:0] clr_r, clr_f;
    logic [NPADS-1:0] drop_r, drop_f;
    logic             sel_valid;
    logic             sel_rising;
    logic [5:0]       sel_pad;
    logic [6:0]       fifo_mem [DEPTH];
    logic [6:0]       head;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             full, push, pop;
    logic [15:0]      drop_sum;
    logic [16:0]      drop_total;

    // The arm counter holds off detection until s3 has seen a real sampled level,
    // so pads already high at reset release never produce an event.
    always_ff @(posedge clock or negedge rstb_l) begin
        if (!rstb_l) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            arm_cnt <= 2'd0;
        end else begin
            s1 <= gpio_in;
            s2 <= s1;
            s3 <= s2;
            if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
        end
    end

    assign armed     = (arm_cnt == 2'd3);
    assign gpio_sync = s2;
    assign edge_r    = {NPADS{armed & rise_en}} & enable_mask & s2 & ~s3;
    assign edge_f    = {NPADS{armed & fall_en}} & enable_mask & ~s2 & s3;

    // Lowest pad index wins; rising is served before falling on the same pad.
    always_comb begin
        sel_valid  = 1'b0;
        sel_pad    = '0;
        sel_rising = 1'b0;
        for (int i = 0; i < NPADS; i++) begin
            if (!sel_valid && (pend_r[i] || pend_f[i])) begin
                sel_valid  = 1'b1;
                sel_pad    = 6'(i);
                sel_rising = pend_r[i];
            end
        end
    end

    always_comb begin
        clr_r = '0;
        clr_f = '0;
        for (int i = 0; i < NPADS; i++) begin
            clr_r[i] = push & sel_rising & (sel_pad == 6'(i));
            clr_f[i] = push & ~sel_rising & (sel_pad == 6'(i));
        end
    end

    assign drop_r = edge_r & pend_r & ~clr_r;
    assign drop_f = edge_f & pend_f & ~clr_f;

    // A new edge landing on a bit being pushed this cycle re-arms it rather than being lost.
    always_ff @(posedge clock or negedge rstb_l) begin
        if (!rstb_l) begin
            pend_r <= '0;
            pend_f <= '0;
        end else begin
            pend_r <= enable_mask & ((pend_r & ~clr_r) | edge_r);
            pend_f <= enable_mask & ((pend_f & ~clr_f) | edge_f);
        end
    end

    always_comb begin
        drop_sum = '0;
        for (int i = 0; i < NPADS; i++) begin
            drop_sum = drop_sum + 16'(drop_r[i]) + 16'(drop_f[i]);
        end
    end

    assign drop_total = {9'd0, drop_count} + {1'b0, drop_sum};

    always_ff @(posedge clock or negedge rstb_l) begin
        if (!rstb_l) begin
            drop_count <= '0;
        end else if (clear_drop) begin
            drop_count <= '0;
        end else if (drop_total > 17'd255) begin
            drop_count <= 8'd255;
        end else begin
            drop_count <= drop_total[7:0];
        end
    end

    // FIFO handshake: an entry leaves only on evt_valid & evt_ready; a push into a full
    // FIFO is allowed when the head is popped in the same cycle.
    assign full      = (count == (AW+1)'(DEPTH));
    assign evt_valid = (count != '0);
    assign pop       = evt_valid & evt_ready;
    assign push      = sel_valid & (~full | pop);

    always_ff @(posedge clock or negedge rstb_l) begin
        if (!rstb_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= {sel_pad, sel_rising};
    end

    assign head       = fifo_mem[rd_ptr];
    assign evt_pad    = evt_valid ? head[6:1] : 6'd0;
    assign evt_rising = evt_valid & head[0];

endmodule

// File: doc/openframe_gpio_event.md
OPENFRAME_GPIO_EVENT -- requirements
Module: openframe_gpio_event

Interface
REQ-001 Parameter NPADS, default 44, number of openframe GPIO pads monitored.
REQ-002 Parameter DEPTH, default 8, event FIFO entries (power of two).
REQ-003 clock  input  1  sole clock; all state on rising edge.
REQ-004 rstb_l  input  1  asynchronous, active-low reset.
REQ-005 gpio_in  input  NPADS  raw pad inputs (1.8V domain), asynchronous to clock.
REQ-006 enable_mask  input  NPADS  per-pad detection enable, 1 = monitored.
REQ-007 rise_en  input  1  report rising edges.
REQ-008 fall_en  input  1  report falling edges.
REQ-009 gpio_sync  output  NPADS  synchronized pad levels.
REQ-010 evt_valid  output  1  FIFO head holds an event.
REQ-011 evt_ready  input  1  consumer accepts head when evt_valid=1.
REQ-012 evt_pad  output  6  pad index of head event.
REQ-013 evt_rising  output  1  1 = rising, 0 = falling, for head event.
REQ-014 drop_count  output  8  saturating count of lost edges.
REQ-015 clear_drop  input  1  synchronous clear of drop_count.

Function
REQ-016 Each gpio_in bit SHALL pass two flops (s1, s2); gpio_sync = s2; a third flop s3 SHALL hold the previous s2.
REQ-017 Rising edge on pad p SHALL be s2[p]=1 & s3[p]=0; falling s2[p]=0 & s3[p]=1; qualified by enable_mask[p], rise_en/fall_en and armed.
REQ-018 A 2-bit arm counter SHALL count 0..3 after reset release; armed=1 only at 3, suppressing spurious edges from reset values.
REQ-019 Qualified edges SHALL set per-pad pending bits pend_r[p]/pend_f[p] (registered).
REQ-020 Each cycle a combinational arbiter SHALL select the lowest pad index with any pending bit; rising before falling for the same pad; at most one push per cycle.
REQ-021 Push SHALL occur when a selection exists and FIFO not full, or full with a pop in the same cycle; the pushed pending bit SHALL clear.
REQ-022 If a new edge of the same polarity sets a bit being cleared by push in the same cycle, the bit SHALL remain set.
REQ-023 Qualified edge arriving while its pending bit is already set and not being cleared SHALL be lost and increment drop_count.
REQ-024 drop_count SHALL saturate at 255; clear_drop SHALL take priority over a concurrent increment (result 0).
REQ-025 Deasserting enable_mask[p] SHALL clear pend_r[p] and pend_f[p] next cycle without counting a drop.
REQ-026 FIFO SHALL be first-word-fall-through; evt_pad/evt_rising valid whenever evt_valid=1 and stable until popped.
REQ-027 Pop SHALL occur only on evt_valid & evt_ready; evt_ready while empty SHALL be ignored.
REQ-028 Latency: gpio_in change captured by s1 at edge k SHALL give evt_valid=1 after edge k+3, FIFO empty and no lower-index pending.
REQ-029 Throughput: one event per cycle sustained with evt_ready held high.
REQ-030 Pointers SHALL wrap modulo DEPTH; occupancy counter width log2(DEPTH)+1.

Reset
REQ-031 rstb_l=0 SHALL immediately clear s1, s2, s3, arm counter, pending bits, FIFO pointers/occupancy, drop_count.
REQ-032 During reset: evt_valid=0, evt_pad=0, evt_rising=0, gpio_sync=0, drop_count=0.
REQ-033 Reset mid-operation SHALL discard all queued and pending events; no event reported for levels present at release.

Verification
REQ-034 Reset release with gpio_in[5]=1 held -> no event ever; gpio_sync[5]=1 after 2 edges.
REQ-035 rise_en=1, gpio_in[3] 0->1 -> evt_valid after 3 edges, evt_pad=3, evt_rising=1; evt_ready pop -> evt_valid=0.
REQ-036 Pads 7 and 2 rise same cycle, evt_ready=1 -> pad 2 then pad 7 on consecutive cycles.
REQ-037 evt_ready=0, 10 single edges on distinct pads -> 8 queued, 2 held pending, drop_count=0; release evt_ready -> all 10 delivered in order.
REQ-038 evt_ready=0, FIFO full, pad 4 pending rising, pad 4 toggles twice more -> drop_count=1; clear_drop with concurrent drop -> 0.
REQ-039 Assert rstb_l=0 with 5 events queued -> evt_valid=0 immediately; after release none reappear.
